// File: rtl/moore_seq_detector_param_pkg.sv
// Shared types and reset defaults for the
// programmable Moore pattern detector.
package moore_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    MATCH
  } state_e;

  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_LEN     = 4;
  localparam logic       DEF_OVERLAP = 1'b1;

  // Length field must hold MAX_LEN+1 so
  // out-of-range loads can be rejected.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/moore_seq_detector_param_if.sv
// Serial-bit, config and status bundle of the
// pattern detector.
interface moore_seq_detector_param_if
  import moore_seq_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) ();

  localparam int LEN_W = len_w(MAX_LEN);

  logic               en;
  logic               in_valid;
  logic               in;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  modport master (
    output en,
    output in_valid,
    output in,
    output cfg_load,
    output cfg_pattern,
    output cfg_len,
    output cfg_overlap,
    output cnt_clr,
    input  out,
    input  match_cnt,
    input  cfg_err
  );

  modport slave (
    input  en,
    input  in_valid,
    input  in,
    input  cfg_load,
    input  cfg_pattern,
    input  cfg_len,
    input  cfg_overlap,
    input  cnt_clr,
    output out,
    output match_cnt,
    output cfg_err
  );

endinterface

// File: rtl/moore_seq_detector_param_sat_counter.sv
// Saturating event counter; clear and increment
// in the same cycle leaves a count of one.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_W'(inc);
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/moore_seq_detector_param.sv
// Run-time programmable Moore serial pattern
// detector with overlap select and match count.
module moore_seq_detector_param
  import moore_seq_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic rst,
  moore_seq_detector_param_if.slave bus
);

  localparam int LEN_W = len_w(MAX_LEN);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               err_q, err_d;
  logic               out_q;

  logic [MAX_LEN-1:0] shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN:0]   mask_w;
  logic [MAX_LEN-1:0] mask;
  logic               len_ok;
  logic               hit;

  assign shift = {hist_q[MAX_LEN-2:0], bus.in};

  assign fill_inc = (fill_q >= len_q) ? len_q
                  : fill_q + LEN_W'(1);

  // Only the low len bits of history take part
  // in the compare.
  assign mask_w = (MAX_LEN+1)'(1) << len_q;
  assign mask   = MAX_LEN'(mask_w - (MAX_LEN+1)'(1));

  assign len_ok = (bus.cfg_len != '0) &&
                  (bus.cfg_len <= LEN_W'(MAX_LEN));

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    err_d   = err_q;
    hit     = 1'b0;
    if (bus.cfg_load) begin
      hist_d  = '0;
      fill_d  = '0;
      state_d = bus.en ? SCAN : IDLE;
      if (len_ok) begin
        pat_d = bus.cfg_pattern;
        len_d = bus.cfg_len;
        ovl_d = bus.cfg_overlap;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (!bus.en) begin
      state_d = IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = SCAN;
    end else if (bus.in_valid) begin
      hist_d = shift;
      fill_d = fill_inc;
      hit = (fill_inc == len_q) &&
            (((shift ^ pat_q) & mask) == '0);
      state_d = hit ? MATCH : SCAN;
      if (hit && !ovl_q) begin
        fill_d = '0;
      end
    end else begin
      state_d = SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= MAX_LEN'(DEF_PATTERN);
      len_q   <= LEN_W'(DEF_LEN);
      ovl_q   <= DEF_OVERLAP;
      err_q   <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      err_q   <= err_d;
      out_q   <= (state_d == MATCH);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (bus.cnt_clr),
    .cnt_o (bus.match_cnt)
  );

  assign bus.out     = out_q;
  assign bus.cfg_err = err_q;

endmodule
